// File: rtl/marcador_pkg.sv
// Shared definitions for the game scoreboard controller.
//   state_t   : FSM encoding, also the value driven on the estado output
//   VEL_MAX   : highest speed level
//   RATE_HZ   : game-step rate per speed level
//   PESO      : score weight per speed level
//   div_of()  : clock cycles per game step for a clock frequency and level
//   peso_of() : score weight for a level, as a 16-bit adder operand
package marcador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [2:0] VEL_MAX = 3'd5;

    localparam int unsigned RATE_HZ [6] = '{1, 2, 5, 10, 50, 99};
    localparam int unsigned PESO    [6] = '{1, 2, 5, 10, 50, 99};

    // Out-of-range levels are clamped so the table lookup is always legal.
    function automatic int unsigned level_idx(input logic [2:0] vel);
        if (vel > VEL_MAX) begin
            return 5;
        end
        return {29'd0, vel};
    endfunction

    // floor(clk_hz / rate); never 0, so the counter terminal value div-1 stays valid.
    function automatic logic [31:0] div_of(input int unsigned clk_hz, input logic [2:0] vel);
        int unsigned q;
        q = clk_hz / RATE_HZ[level_idx(vel)];
        if (q == 0) begin
            q = 1;
        end
        return q;
    endfunction

    function automatic logic [15:0] peso_of(input logic [2:0] vel);
        return 16'(PESO[level_idx(vel)]);
    endfunction

endpackage

// File: rtl/marcador_tick_gen.sv
// Game-step divider.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : advance the counter this cycle
//   clear      : force the counter to 0 (wins over enable)
//   div        : cycles per step; counter runs 0..div-1 and wraps
//   tick       : registered, high exactly while the counter shows div-1
module tick_gen
    import marcador_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear,
    input  logic [31:0] div,
    output logic        tick
);

    logic [31:0] cnt_q, cnt_d;
    logic        tick_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            // >= rather than == so a shrinking div can never strand the counter above it.
            cnt_d = (cnt_q >= div - 32'd1) ? '0 : cnt_q + 32'd1;
        end
    end

    // The tick is registered alongside the counter, so it is computed from the
    // counter's next value to line up with the cycle that shows div-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= enable && (cnt_d == div - 32'd1);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/marcador_ctrl.sv
// Game scoreboard controller: game FSM, speed level, score, and game-step tick.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, pausa      : pulses: new game / toggle pause
//   vel_up, vel_down  : pulses: speed level +1 / -1 (saturating 0..5)
//   punto, fin        : pulses: scoring event / game over
//   velocidad         : speed level 0..5
//   puntuacion        : binary score 0..SCORE_MAX
//   tick              : one-cycle game-step strobe
//   estado            : FSM state (IDLE=00 RUN=01 PAUSE=10 OVER=11)
// Every output comes straight from a register.
module marcador_ctrl
    import marcador_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SCORE_MAX = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pausa,
    input  logic        vel_up,
    input  logic        vel_down,
    input  logic        punto,
    input  logic        fin,
    output logic [2:0]  velocidad,
    output logic [13:0] puntuacion,
    output logic        tick,
    output logic [1:0]  estado
);

    localparam logic [15:0] SCORE_MAX_W = 16'(SCORE_MAX);

    state_t      state_q, state_d;
    logic [2:0]  vel_q, vel_d;
    logic [13:0] score_q, score_d;
    logic [15:0] sum;
    logic        start_ok;
    logic        cnt_en, cnt_clr;
    logic [31:0] div;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_OVER: if (start) state_d = ST_RUN;
            // fin wins over a simultaneous pausa
            ST_RUN:           if (fin) state_d = ST_OVER;
                              else if (pausa) state_d = ST_PAUSE;
            ST_PAUSE:         if (pausa) state_d = ST_RUN;
            default:          state_d = state_q;
        endcase

        start_ok = start && (state_q == ST_IDLE || state_q == ST_OVER);

        // Both buttons in one cycle cancel out; speed is frozen once the game is over.
        vel_d = vel_q;
        if (state_q != ST_OVER && vel_up != vel_down) begin
            if (vel_up && vel_q < VEL_MAX) begin
                vel_d = vel_q + 3'd1;
            end else if (vel_down && vel_q != 3'd0) begin
                vel_d = vel_q - 3'd1;
            end
        end

        // Weight follows the level in force when the point arrives.
        sum     = {2'b00, score_q} + peso_of(vel_q);
        score_d = score_q;
        if (start_ok) begin
            score_d = '0;
        end else if (state_q == ST_RUN && punto) begin
            score_d = (sum > SCORE_MAX_W) ? SCORE_MAX_W[13:0] : sum[13:0];
        end

        // The counter only advances on edges where the game is and stays running,
        // so the cycle that pauses and the cycle that resumes both leave it frozen:
        // pausing at count c resumes with the next tick div-c cycles after the resume pulse.
        cnt_en  = (state_q == ST_RUN) && (state_d == ST_RUN);
        cnt_clr = start_ok || (vel_d != vel_q) ||
                  (state_d == ST_IDLE) || (state_d == ST_OVER);
        div     = div_of(CLK_HZ, vel_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vel_q   <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            vel_q   <= vel_d;
            score_q <= score_d;
        end
    end

    tick_gen u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (cnt_en),
        .clear  (cnt_clr),
        .div    (div),
        .tick   (tick)
    );

    assign velocidad  = vel_q;
    assign puntuacion = score_q;
    assign estado     = state_q;

endmodule

// File: tb/tb_marcador_ctrl.sv
// Directed bench for marcador_ctrl at CLK_HZ=1000 (DIV = 1000,500,200,100,20,10).
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_marcador_ctrl;

  localparam logic [5:0] P_START = 6'b100000;
  localparam logic [5:0] P_PAUSA = 6'b010000;
  localparam logic [5:0] P_UP    = 6'b001000;
  localparam logic [5:0] P_DOWN  = 6'b000100;
  localparam logic [5:0] P_PUNTO = 6'b000010;
  localparam logic [5:0] P_FIN   = 6'b000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, pausa = 1'b0, vel_up = 1'b0, vel_down = 1'b0, punto = 1'b0, fin = 1'b0;
  logic [2:0]  velocidad;
  logic [13:0] puntuacion;
  logic        tick;
  logic [1:0]  estado;

  int checks = 0;
  int failures = 0;

  marcador_ctrl #(.CLK_HZ(1000), .SCORE_MAX(9999)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pausa      (pausa),
    .vel_up     (vel_up),
    .vel_down   (vel_down),
    .punto      (punto),
    .fin        (fin),
    .velocidad  (velocidad),
    .puntuacion (puntuacion),
    .tick       (tick),
    .estado     (estado)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic pulse(input logic [5:0] m);
    @(negedge clk);
    {start, pausa, vel_up, vel_down, punto, fin} = m;
    @(negedge clk);
    {start, pausa, vel_up, vel_down, punto, fin} = 6'b0;
  endtask

  task automatic pulse_n(input logic [5:0] m, input int n);
    for (int i = 0; i < n; i++) pulse(m);
  endtask

  // cycles from the current sample to the next tick, bounded
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 5000);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({estado, velocidad, puntuacion, tick} !== 20'd0) begin
      failures++;
      $display("FAIL reset_outputs got estado=%0d vel=%0d score=%0d tick=%0d exp all 0", estado, velocidad, puntuacion, tick);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({estado, velocidad, puntuacion, tick} !== 20'd0) begin
      failures++;
      $display("FAIL reset_release got estado=%0d vel=%0d score=%0d tick=%0d exp all 0", estado, velocidad, puntuacion, tick);
    end
  endtask

  task automatic test_start;
    int n;
    pulse(P_START);
    checks++;
    if (estado !== 2'b01) begin failures++; $display("FAIL start_estado got=%0d exp=1", estado); end
    wait_tick(n);
    checks++;
    if (n !== 999) begin failures++; $display("FAIL first_tick got=%0d exp=999 samples after start", n); end
    wait_tick(n);
    checks++;
    if (n !== 1000) begin failures++; $display("FAIL tick_period got=%0d exp=1000", n); end
    @(negedge clk);
    checks++;
    if (tick !== 1'b0) begin failures++; $display("FAIL tick_width got=%0d exp=0", tick); end
  endtask

  task automatic test_speed;
    pulse_n(P_UP, 7);
    checks++;
    if (velocidad !== 3'd5) begin failures++; $display("FAIL vel_sat_hi got=%0d exp=5", velocidad); end
    pulse_n(P_DOWN, 7);
    checks++;
    if (velocidad !== 3'd0) begin failures++; $display("FAIL vel_sat_lo got=%0d exp=0", velocidad); end
    pulse_n(P_UP, 2);
    checks++;
    if (velocidad !== 3'd2) begin failures++; $display("FAIL vel_two got=%0d exp=2", velocidad); end
    pulse(P_UP | P_DOWN);
    checks++;
    if (velocidad !== 3'd2) begin failures++; $display("FAIL vel_both got=%0d exp=2", velocidad); end
  endtask

  task automatic test_score;
    pulse_n(P_UP, 2);
    checks++;
    if (velocidad !== 3'd4) begin failures++; $display("FAIL score_level got=%0d exp=4", velocidad); end
    pulse_n(P_PUNTO, 3);
    checks++;
    if (puntuacion !== 14'd150) begin failures++; $display("FAIL score_150 got=%0d exp=150", puntuacion); end
    pulse_n(P_PUNTO, 177);
    checks++;
    if (puntuacion !== 14'd9000) begin failures++; $display("FAIL score_9000 got=%0d exp=9000", puntuacion); end
    pulse(P_UP);
    pulse_n(P_PUNTO, 10);
    checks++;
    if (puntuacion !== 14'd9990) begin failures++; $display("FAIL score_9990 got=%0d exp=9990", puntuacion); end
    pulse(P_PUNTO);
    checks++;
    if (puntuacion !== 14'd9999) begin failures++; $display("FAIL score_sat got=%0d exp=9999", puntuacion); end
    pulse(P_PUNTO);
    checks++;
    if (puntuacion !== 14'd9999) begin failures++; $display("FAIL score_sat_hold got=%0d exp=9999", puntuacion); end
  endtask

  task automatic test_priority;
    pulse(P_FIN | P_PAUSA);
    checks++;
    if (estado !== 2'b11) begin failures++; $display("FAIL fin_over_pausa got=%0d exp=3", estado); end
    pulse(P_DOWN);
    checks++;
    if (velocidad !== 3'd5) begin failures++; $display("FAIL vel_in_over got=%0d exp=5", velocidad); end
    pulse(P_PUNTO);
    checks++;
    if (puntuacion !== 14'd9999) begin failures++; $display("FAIL punto_in_over got=%0d exp=9999", puntuacion); end
    pulse(P_PAUSA);
    checks++;
    if (estado !== 2'b11) begin failures++; $display("FAIL pausa_in_over got=%0d exp=3", estado); end
  endtask

  task automatic test_pause;
    int n;
    int ticks;
    pulse(P_START);
    checks++;
    if ({estado, velocidad, puntuacion} !== {2'b01, 3'd5, 14'd0}) begin
      failures++;
      $display("FAIL restart got estado=%0d vel=%0d score=%0d exp 1/5/0", estado, velocidad, puntuacion);
    end
    // last level change leaves the counter at 0 on this sample
    pulse_n(P_DOWN, 5);
    repeat (299) @(negedge clk);
    pulse(P_PAUSA);
    checks++;
    if (estado !== 2'b10) begin failures++; $display("FAIL pause_estado got=%0d exp=2", estado); end
    pulse(P_PUNTO);
    checks++;
    if (puntuacion !== 14'd0) begin failures++; $display("FAIL punto_in_pause got=%0d exp=0", puntuacion); end
    ticks = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    checks++;
    if (ticks !== 0) begin failures++; $display("FAIL pause_ticks got=%0d exp=0", ticks); end
    pulse(P_PAUSA);
    checks++;
    if (estado !== 2'b01) begin failures++; $display("FAIL resume_estado got=%0d exp=1", estado); end
    wait_tick(n);
    checks++;
    if (n !== 699) begin failures++; $display("FAIL resume_tick got=%0d exp=699 samples after resume", n); end
  endtask

  task automatic test_sequence;
    pulse_n(P_PUNTO, 7);
    checks++;
    if (puntuacion !== 14'd7) begin failures++; $display("FAIL seq_score7 got=%0d exp=7", puntuacion); end
    pulse(P_PUNTO | P_FIN);
    checks++;
    if ({estado, puntuacion} !== {2'b11, 14'd8}) begin
      failures++;
      $display("FAIL punto_fin got estado=%0d score=%0d exp 3/8", estado, puntuacion);
    end
    pulse(P_PUNTO);
    checks++;
    if (puntuacion !== 14'd8) begin failures++; $display("FAIL punto_after_over got=%0d exp=8", puntuacion); end
    pulse(P_START);
    checks++;
    if ({estado, puntuacion} !== {2'b01, 14'd0}) begin
      failures++;
      $display("FAIL seq_start got estado=%0d score=%0d exp 1/0", estado, puntuacion);
    end
    pulse_n(P_UP, 2);
    pulse(P_PUNTO);
    checks++;
    if ({velocidad, puntuacion} !== {3'd2, 14'd5}) begin
      failures++;
      $display("FAIL seq_level2 got vel=%0d score=%0d exp 2/5", velocidad, puntuacion);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({estado, velocidad, puntuacion, tick} !== 20'd0) begin
      failures++;
      $display("FAIL async_reset got estado=%0d vel=%0d score=%0d tick=%0d exp all 0", estado, velocidad, puntuacion, tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({estado, velocidad, puntuacion, tick} !== 20'd0) begin
      failures++;
      $display("FAIL release_cycle got estado=%0d vel=%0d score=%0d tick=%0d exp all 0", estado, velocidad, puntuacion, tick);
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_start();
    test_speed();
    test_score();
    test_priority();
    test_pause();
    test_sequence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/marcador_ctrl.md
MARCADOR_CTRL -- requirements
Module: marcador_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter CLK_HZ, default 50_000_000, clock frequency in Hz.
REQ-003 Parameter SCORE_MAX, default 9999, score saturation value (must fit 14 bits).
REQ-004 Ports SHALL be:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin a new game.
- pausa  in  1  one-cycle pulse: toggle pause.
- vel_up  in  1  one-cycle pulse: speed level +1.
- vel_down  in  1  one-cycle pulse: speed level -1.
- punto  in  1  one-cycle pulse: one scoring event.
- fin  in  1  one-cycle pulse: game over.
- velocidad  out  3  speed level 0..5, drives the display block.
- puntuacion  out  14  binary score 0..SCORE_MAX, drives the display block.
- tick  out  1  one-cycle game-step strobe.
- estado  out  2  current FSM state.

Function
REQ-005 FSM states SHALL be IDLE=00, RUN=01, PAUSE=10, OVER=11, encoded as driven on estado.
REQ-006 Transitions SHALL be:
- IDLE or OVER: start -> RUN.
- RUN: fin -> OVER, else pausa -> PAUSE.
- PAUSE: pausa -> RUN.
- All other inputs leave the state unchanged.
REQ-007 fin in RUN SHALL take priority over a simultaneous pausa.
REQ-008 Speed level handling:
- vel_up SHALL increment velocidad, saturating at 5.
- vel_down SHALL decrement velocidad, saturating at 0.
- Both asserted in the same cycle SHALL leave velocidad unchanged.
- Speed pulses SHALL be ignored in OVER.
REQ-009 Speed rate table SHALL map level 0..5 to rate {1,2,5,10,50,99} Hz, and DIV[v] SHALL equal floor(CLK_HZ/rate[v]).
REQ-010 Tick counter behaviour:
- In RUN the counter SHALL count 0..DIV[v]-1 and wrap to 0.
- tick SHALL be asserted for exactly the cycle in which the counter equals DIV[v]-1.
REQ-011 The tick counter SHALL hold its value in PAUSE, SHALL be 0 in IDLE and OVER, and SHALL be cleared on any change of velocidad.
REQ-012 The first tick after entering RUN from IDLE or OVER SHALL occur DIV[v] cycles after the start pulse.
REQ-013 Scoring:
- In RUN each punto SHALL add weight PESO[v]={1,2,5,10,50,99} to puntuacion.
- A sum exceeding SCORE_MAX SHALL saturate at SCORE_MAX.
REQ-014 punto SHALL be ignored in IDLE, PAUSE and OVER.
REQ-015 punto coincident with fin in RUN SHALL be scored in the same cycle the FSM moves to OVER.
REQ-016 start SHALL clear puntuacion to 0 and clear the tick counter; velocidad SHALL be preserved.
REQ-017 All outputs SHALL be registered, with state/score/speed updates visible one cycle after the input pulse and no combinational input-to-output path.

Reset
REQ-018 While rst_n=0 the block SHALL asynchronously force: estado=IDLE, velocidad=0, puntuacion=0, tick=0, tick counter=0.
REQ-019 Reset asserted mid-game SHALL abort immediately, with no tick or score update in the release cycle.

Structure
REQ-020 Package marcador_pkg SHALL hold:
- state encoding;
- VEL_MAX=5;
- rate table;
- PESO weight table;
- DIV computation function.
REQ-021 The divider SHALL be a sub-module tick_gen (inputs: enable, clear, div; output: tick); FSM, speed and score logic SHALL stay in marcador_ctrl.

Verification (CLK_HZ=1000, so DIV={1000,500,200,100,20,10})
REQ-022 Reset, then start at level 0 -> estado=01 next cycle; first tick 1000 cycles after start; subsequent ticks every 1000 cycles.
REQ-023 Seven vel_up pulses -> velocidad=5; seven vel_down pulses -> velocidad=0; vel_up and vel_down together at level 2 -> level stays 2.
REQ-024 Level 4, three punto pulses -> puntuacion=150; level 5 with score 9990, one punto -> 9999; a further punto -> 9999.
REQ-025 Level 0, pausa when counter=300 -> no tick during 5000 PAUSE cycles; pausa again -> next tick 700 cycles later.
REQ-026 Sequence:
- punto and fin in the same cycle at level 0, score 7 -> score=8, estado=11.
- Later punto -> no change.
- start -> score=0, estado=01.
- rst_n low mid-RUN -> all outputs 0 without a clock edge.
